ram_sdp_clr: RTL and testbench
==============================

Name: ram_sdp_clr

Overview:
- Parametrised simple dual-port synchronous RAM: one write port and one read port on a single clock.
- Generalises the team's 128x8 single-port RAM in three ways:
  - configurable width and depth;
  - selectable read-during-write mode and optional output register;
  - a built-in clear engine that zero-fills the array after reset or on request, with a read-valid handshake.
- Used as the storage primitive under upcoming FIFOs and register files in the practicals.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADDR_W, 7, address width; DEPTH = 2**ADDR_W words (default 128).
- RDW_MODE, 0, same-address read-during-write behaviour: 0 = old data, 1 = new data (write-first bypass).
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  single-cycle request to zero-fill the whole array.
- busy  out  1  high while the clear engine runs; user accesses are ignored.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- rd_en  in  1  read request.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  read data, valid when rvalid=1.
- rvalid  out  1  rdata qualifier; one pulse per accepted read.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=CLEAR, clr_ptr=0, busy=1, rdata=0, rvalid=0, pipeline valids=0.
  - Memory array contents are not reset; the clear engine zeroes them afterwards.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to mem[clr_ptr], then clr_ptr++. When clr_ptr==DEPTH-1 the write occurs and the next state is IDLE, with busy low from that edge.
  - Clear duration: exactly DEPTH cycles after rst_n release or after clr is sampled.
  - IDLE: clr=1 -> CLEAR with clr_ptr=0; busy=1 from the next edge.
  - clr=1 while in CLEAR restarts the sweep: clr_ptr=0, full DEPTH cycles again.
- busy=1: we and rd_en are ignored. No array write, no rvalid pulse, rdata holds its last value.
- Write (IDLE, we=1): mem[waddr] <= wdata on the rising edge.
- Read (IDLE, rd_en=1), captured at edge N:
  - OUT_REG=0: rdata and rvalid=1 appear after edge N.
  - OUT_REG=1: they appear after edge N+1.
  - rvalid is a 1-cycle pulse per accepted read; back-to-back rd_en gives back-to-back rvalid (full throughput).
  - rdata holds its value when no read completes.
- Same-address collision (we=1, rd_en=1, waddr==raddr, same edge):
  - RDW_MODE=0: returns the pre-write contents.
  - RDW_MODE=1: returns wdata.
  - Different addresses: independent, no interaction.
- clr asserted the same cycle as an accepted read in IDLE:
  - the read still completes with pre-clear data;
  - a write in that cycle is performed, then overwritten by the sweep.
- Reset asserted mid-read with OUT_REG=1 flushes the pipeline; no rvalid is produced for that read.
- Address arithmetic: clr_ptr is ADDR_W bits and never wraps past DEPTH-1; waddr and raddr are always in range (power-of-two depth).

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_CLEAR);
  - RDW_MODE constants (RDW_OLD=0, RDW_NEW=1).
- One natural sub-module, ram_sdp_core: the bare array with one write port and a registered read port, parametrised DATA_W/ADDR_W/RDW_MODE.
- The top level adds the clear FSM, write-port muxing (sweep vs user), the OUT_REG stage and rvalid tracking.

Test Plan:
- Reset then wait: release rst_n -> busy=1 for exactly 128 cycles, then 0; read of addr 0, 64 and 127 -> rdata=0x00, rvalid one cycle after rd_en.
- Write/read, OUT_REG=0: write 0xA5 to addr 5, next cycle read addr 5 -> rvalid and rdata=0xA5 one cycle later. With OUT_REG=1 -> same data, two cycles later.
- Collision: addr 9 holds 0x11; write 0x22 to addr 9 and read addr 9 on the same edge -> rdata=0x11 (RDW_MODE=0) or 0x22 (RDW_MODE=1); subsequent read -> 0x22.
- Busy lockout: pulse clr, then write 0x7E to addr 3 and read addr 3 during busy -> no rvalid. After busy falls, read addr 3 -> 0x00.
- clr restart: pulse clr, pulse clr again 50 cycles later -> busy stays high 128 cycles after the second pulse (178 total).
- Streaming plus mid-operation reset: rd_en for 4 consecutive cycles on addrs 0-3 holding 1,2,3,4 -> four consecutive rvalid with rdata 1,2,3,4. Assert rst_n=0 during the stream (OUT_REG=1) -> rvalid=0 and rdata=0 immediately.

Source files
------------

// File: rtl/ram_sdp_clr_pkg.sv
// Shared types and constants for the clearable simple dual-port RAM.
package ram_sdp_clr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

endpackage

// File: rtl/ram_sdp_clr_if.sv
// User-side bus of ram_sdp_clr: clear request, write port, read port with valid.
interface ram_sdp_clr_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 7
);
  logic              clr;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output clr, we, waddr, wdata, rd_en, raddr,
    input  busy, rdata, rvalid
  );

  modport slave (
    input  clr, we, waddr, wdata, rd_en, raddr,
    output busy, rdata, rvalid
  );
endinterface

// File: rtl/ram_sdp_core.sv
// Bare storage array: one write port, one registered read port, selectable
// read-during-write behaviour on a same-address collision.
module ram_sdp_core
  import ram_sdp_clr_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned RDW_MODE = RDW_OLD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH       = 2 ** ADDR_W;
  localparam bit          WRITE_FIRST = (RDW_MODE == RDW_NEW);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              bypass_c;

  assign bypass_c = WRITE_FIRST && we && (waddr == raddr);

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= bypass_c ? wdata : mem[raddr];
  end

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple dual-port RAM with a zero-fill clear engine, optional output register
// and a read-valid pulse per accepted read.
module ram_sdp_clr
  import ram_sdp_clr_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned RDW_MODE = RDW_OLD,
  parameter int unsigned OUT_REG  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_sdp_clr_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic              busy_q, busy_nxt;
  logic              rd_v;

  logic              sweep_c;
  logic              rd_acc_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] core_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      busy_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Sweep one word per cycle; a clr request always restarts from word 0.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      ST_CLEAR: begin
        if (bus.clr) begin
          clr_ptr_nxt = '0;
        end else if (clr_ptr == LAST_PTR) begin
          state_nxt = ST_IDLE;
        end else begin
          clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.clr) begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
    busy_nxt = (state_nxt == ST_CLEAR);
  end

  assign sweep_c     = (state == ST_CLEAR);
  assign rd_acc_c    = bus.rd_en && !sweep_c;
  assign mem_we_c    = sweep_c || bus.we;
  assign mem_waddr_c = sweep_c ? clr_ptr : bus.waddr;
  assign mem_wdata_c = sweep_c ? '0 : bus.wdata;

  ram_sdp_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RDW_MODE (RDW_MODE)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we_c),
    .waddr (mem_waddr_c),
    .wdata (mem_wdata_c),
    .re    (rd_acc_c),
    .raddr (bus.raddr),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_v <= 1'b0;
    else        rd_v <= rd_acc_c;
  end

  // Optional second stage; reset flushes any read still in flight.
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_v;
        if (rd_v) rdata_q <= core_rdata;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end else begin : g_noreg
    assign bus.rdata  = core_rdata;
    assign bus.rvalid = rd_v;
  end

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: two instances (old-data/1-cycle and new-data/2-cycle)
// driven identically and checked every cycle against an array-level model.
module tb_ram_sdp_clr;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 7;
  localparam int          DEPTH = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_sdp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  ram_sdp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  ram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  ram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left;
  logic          e_rv0, e_rv1, p_v;
  logic [DW-1:0] e_d0, e_d1, p_d;

  typedef struct {
    logic          clr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          rd_en;
    logic [AW-1:0] raddr;
    logic          rv0;
    logic [DW-1:0] d0;
    logic          rv1;
    logic [DW-1:0] d1;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = DEPTH;
    e_rv0 = 1'b0; e_rv1 = 1'b0; p_v = 1'b0;
    e_d0 = '0; e_d1 = '0; p_d = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  task automatic model_edge(input logic c, input logic w, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra);
    logic          busy_b, rd_ok;
    logic [DW-1:0] old_v, new_v;
    busy_b = (m_left > 0);
    rd_ok  = r && !busy_b;
    old_v  = m_mem[ra];
    new_v  = (w && wa == ra) ? wd : old_v;
    e_rv1 = p_v;
    if (p_v) e_d1 = p_d;
    p_v = rd_ok;
    p_d = new_v;
    e_rv0 = rd_ok;
    if (rd_ok) e_d0 = old_v;
    if (busy_b) begin
      m_left = c ? DEPTH : m_left - 1;
    end else begin
      if (w) m_mem[wa] = wd;
      if (c) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_left = DEPTH;
      end
    end
  endtask

  task automatic compare_all();
    chk("busy0",   32'(bus0.busy),   32'(m_left > 0));
    chk("busy1",   32'(bus1.busy),   32'(m_left > 0));
    chk("rvalid0", 32'(bus0.rvalid), 32'(e_rv0));
    chk("rdata0",  32'(bus0.rdata),  32'(e_d0));
    chk("rvalid1", 32'(bus1.rvalid), 32'(e_rv1));
    chk("rdata1",  32'(bus1.rdata),  32'(e_d1));
  endtask

  task automatic step(input logic c, input logic w, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra);
    bus0.clr = c; bus0.we = w; bus0.waddr = wa; bus0.wdata = wd; bus0.rd_en = r; bus0.raddr = ra;
    bus1.clr = c; bus1.we = w; bus1.waddr = wa; bus1.wdata = wd; bus1.rd_en = r; bus1.raddr = ra;
    @(posedge clk);
    if (rst_n) model_edge(c, w, wa, wd, r, ra);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Steps until busy drops; returns the number of steps taken.
  task automatic wait_idle(output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (bus0.busy && n < 1000);
  endtask

  initial begin
    int n, hi;
    vecs[0]  = '{1'b0, 1'b1, 7'd5, 8'hA5, 1'b0, 7'd0, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 7'd5, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 7'd9, 8'h11, 1'b0, 7'd0, 1'b0, 8'hA5, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 1'b1, 7'd9, 8'h22, 1'b1, 7'd9, 1'b1, 8'h11, 1'b0, 8'hA5};
    vecs[4]  = '{1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 7'd9, 1'b1, 8'h22, 1'b1, 8'h22};
    vecs[5]  = '{1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 1'b0, 8'h22, 1'b1, 8'h22};
    vecs[6]  = '{1'b0, 1'b1, 7'd0, 8'h01, 1'b0, 7'd0, 1'b0, 8'h22, 1'b0, 8'h22};
    vecs[7]  = '{1'b0, 1'b1, 7'd1, 8'h02, 1'b0, 7'd0, 1'b0, 8'h22, 1'b0, 8'h22};
    vecs[8]  = '{1'b0, 1'b1, 7'd2, 8'h03, 1'b0, 7'd0, 1'b0, 8'h22, 1'b0, 8'h22};
    vecs[9]  = '{1'b0, 1'b1, 7'd3, 8'h04, 1'b0, 7'd0, 1'b0, 8'h22, 1'b0, 8'h22};
    vecs[10] = '{1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 7'd0, 1'b1, 8'h01, 1'b0, 8'h22};
    vecs[11] = '{1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 7'd1, 1'b1, 8'h02, 1'b1, 8'h01};
    vecs[12] = '{1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 7'd2, 1'b1, 8'h03, 1'b1, 8'h02};
    vecs[13] = '{1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 7'd3, 1'b1, 8'h04, 1'b1, 8'h03};
    vecs[14] = '{1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 1'b0, 8'h04, 1'b1, 8'h04};
    vecs[15] = '{1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 1'b0, 8'h04, 1'b0, 8'h04};

    // Reset and power-up sweep
    rst_n = 1'b0;
    bus0.clr = 0; bus0.we = 0; bus0.waddr = '0; bus0.wdata = '0; bus0.rd_en = 0; bus0.raddr = '0;
    bus1.clr = 0; bus1.we = 0; bus1.waddr = '0; bus1.wdata = '0; bus1.rd_en = 0; bus1.raddr = '0;
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;
    wait_idle(n);
    chk("reset_busy_len", 32'(n), 32'd128);

    step(1'b0, 1'b0, '0, '0, 1'b1, 7'd0);
    chk("rd0_after_reset", {23'd0, bus0.rvalid, bus0.rdata}, {23'd0, 1'b1, 8'h00});
    step(1'b0, 1'b0, '0, '0, 1'b1, 7'd64);
    step(1'b0, 1'b0, '0, '0, 1'b1, 7'd127);
    idle();

    // Accesses during a clear are ignored
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 7'd3, 8'h7E, 1'b1, 7'd3);
    chk("lockout_rvalid0", 32'(bus0.rvalid), 32'd0);
    wait_idle(n);
    chk("clr_busy_len", 32'(n), 32'd127);
    step(1'b0, 1'b0, '0, '0, 1'b1, 7'd3);
    chk("lockout_rd3", {23'd0, bus0.rvalid, bus0.rdata}, {23'd0, 1'b1, 8'h00});
    idle();

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].clr, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].rd_en, vecs[i].raddr);
      chk($sformatf("vec%0d_rv0", i), 32'(bus0.rvalid), 32'(vecs[i].rv0));
      chk($sformatf("vec%0d_d0", i),  32'(bus0.rdata),  32'(vecs[i].d0));
      chk($sformatf("vec%0d_rv1", i), 32'(bus1.rvalid), 32'(vecs[i].rv1));
      chk($sformatf("vec%0d_d1", i),  32'(bus1.rdata),  32'(vecs[i].d1));
    end

    // Clear restart 50 cycles into a sweep
    hi = 0;
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    if (bus0.busy) hi++;
    for (int i = 0; i < 49; i++) begin
      idle();
      if (bus0.busy) hi++;
    end
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    if (bus0.busy) hi++;
    n = 0;
    while (bus0.busy && n < 1000) begin
      idle();
      if (bus0.busy) hi++;
      n++;
    end
    chk("restart_busy_len", 32'(hi), 32'd178);

    // Streaming read interrupted by reset
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, AW'(i), DW'(i + 1), 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 7'd0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 7'd1);
    chk("stream_rv1_pre", {23'd0, bus1.rvalid, bus1.rdata}, {23'd0, 1'b1, 8'h01});
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_rvalid1", 32'(bus1.rvalid), 32'd0);
    chk("midrst_rdata1",  32'(bus1.rdata),  32'd0);
    chk("midrst_rdata0",  32'(bus0.rdata),  32'd0);
    chk("midrst_busy",    32'(bus0.busy),   32'd1);
    #1;
    rst_n = 1'b1;
    idle();
    chk("midrst_no_rvalid1", 32'(bus1.rvalid), 32'd0);
    wait_idle(n);
    chk("midrst_busy_len", 32'(n), 32'd127);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic          c, w, r;
      logic [AW-1:0] wa, ra;
      c  = ($urandom_range(0, 399) == 0);
      w  = $urandom_range(0, 1) == 1;
      r  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) begin
        wa = AW'($urandom_range(0, 3));
        ra = AW'($urandom_range(0, 3));
      end else begin
        wa = AW'($urandom);
        ra = AW'($urandom);
      end
      step(c, w, wa, DW'($urandom), r, ra);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
